// File: rtl/reloj_contador_alarma_pkg.sv
// Shared types and constants for the time-of-day / alarm register stage.
// Holds the alarm FSM encoding, counter moduli and field widths.
package reloj_contador_alarma_pkg;

    localparam int SEG_MAX  = 60;
    localparam int MIN_MAX  = 60;
    localparam int ANCHO_MS = 6;
    localparam int ANCHO_H  = 5;
    localparam int ANCHO_RING = 8;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SONANDO = 2'd1,
        ESPERA  = 2'd2
    } estado_t;

endpackage

// File: rtl/reloj_contador_alarma_if.sv
// Bundle between the mode/function selector (master) and the clock stage (slave).
// Carries increment requests, alarm controls, the 1 Hz tick and the display values.
interface reloj_contador_alarma_if;
    import reloj_contador_alarma_pkg::*;

    logic                tick_seg;
    logic                aumentar_min;
    logic                aumentar_hor;
    logic                aumentar_min_al;
    logic                aumentar_hor_al;
    logic                alarma_habil;
    logic                apagar_alarma;
    logic [ANCHO_MS-1:0] segundos;
    logic [ANCHO_MS-1:0] minutos;
    logic [ANCHO_H-1:0]  horas;
    logic [ANCHO_MS-1:0] min_al;
    logic [ANCHO_H-1:0]  hor_al;
    logic                alarma_sonando;

    modport master (
        output tick_seg, aumentar_min, aumentar_hor,
        output aumentar_min_al, aumentar_hor_al,
        output alarma_habil, apagar_alarma,
        input  segundos, minutos, horas,
        input  min_al, hor_al, alarma_sonando
    );

    modport slave (
        input  tick_seg, aumentar_min, aumentar_hor,
        input  aumentar_min_al, aumentar_hor_al,
        input  alarma_habil, apagar_alarma,
        output segundos, minutos, horas,
        output min_al, hor_al, alarma_sonando
    );

endinterface

// File: rtl/reloj_contador_alarma_contador_mod.sv
// Modulo-MODULO counter with increment enable, synchronous clear and carry-out.
// Ports: clk, rst_n, inc, clr in; q (current), q_next (value after this edge), carry out.
module reloj_contador_alarma_contador_mod #(
    parameter int MODULO = 60,
    parameter int ANCHO  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [ANCHO-1:0] q,
    output logic [ANCHO-1:0] q_next,
    output logic             carry
);

    localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(MODULO - 1);

    logic [ANCHO-1:0] cnt_q;
    logic [ANCHO-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        carry = inc && !clr && (cnt_q == ULTIMO);
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = carry ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q      = cnt_q;
    assign q_next = cnt_d;

endmodule

// File: rtl/reloj_contador_alarma.sv
// Time-of-day and alarm register stage with edge-detected increments and alarm FSM.
// Ports: clock, reset (async, active-low), bus (slave side of the selector bundle).
module reloj_contador_alarma
    import reloj_contador_alarma_pkg::*;
#(
    parameter int HORAS_MAX       = 24,
    parameter int DURACION_ALARMA = 60
) (
    input  logic                    clock,
    input  logic                    reset,
    reloj_contador_alarma_if.slave  bus
);

    localparam logic [ANCHO_RING-1:0] DURACION = ANCHO_RING'(DURACION_ALARMA);

    // Previous request levels: {hor_al, min_al, hor, min}
    logic [3:0] prev_q;
    logic [3:0] prev_d;
    logic [3:0] nivel;
    logic [3:0] flanco;

    assign nivel  = {bus.aumentar_hor_al, bus.aumentar_min_al,
                     bus.aumentar_hor, bus.aumentar_min};
    assign prev_d = nivel;
    assign flanco = nivel & ~prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    logic                f_min;
    logic                f_hor;
    logic                f_min_al;
    logic                f_hor_al;

    assign f_min    = flanco[0];
    assign f_hor    = flanco[1];
    assign f_min_al = flanco[2];
    assign f_hor_al = flanco[3];

    logic [ANCHO_MS-1:0] seg;
    logic [ANCHO_MS-1:0] seg_n;
    logic [ANCHO_MS-1:0] min;
    logic [ANCHO_MS-1:0] min_n;
    logic [ANCHO_H-1:0]  hor;
    logic [ANCHO_H-1:0]  hor_n;
    logic [ANCHO_MS-1:0] mal;
    logic [ANCHO_MS-1:0] mal_n;
    logic [ANCHO_H-1:0]  hal;
    logic [ANCHO_H-1:0]  hal_n;
    logic                seg_c;
    logic                min_c;
    logic                hor_c;
    logic                mal_c;
    logic                hal_c;
    logic                inc_seg;
    logic                inc_min;
    logic                inc_hor;

    // A manual minute edge swallows the tick; the manual minute carry
    // never reaches the hours, and a manual hour edge absorbs a tick carry.
    assign inc_seg = bus.tick_seg && !f_min;
    assign inc_min = f_min || seg_c;
    assign inc_hor = f_hor || (min_c && !f_min);

    reloj_contador_alarma_contador_mod #(
        .MODULO (SEG_MAX),
        .ANCHO  (ANCHO_MS)
    ) u_seg (
        .clk    (clock),
        .rst_n  (reset),
        .inc    (inc_seg),
        .clr    (f_min),
        .q      (seg),
        .q_next (seg_n),
        .carry  (seg_c)
    );

    reloj_contador_alarma_contador_mod #(
        .MODULO (MIN_MAX),
        .ANCHO  (ANCHO_MS)
    ) u_min (
        .clk    (clock),
        .rst_n  (reset),
        .inc    (inc_min),
        .clr    (1'b0),
        .q      (min),
        .q_next (min_n),
        .carry  (min_c)
    );

    reloj_contador_alarma_contador_mod #(
        .MODULO (HORAS_MAX),
        .ANCHO  (ANCHO_H)
    ) u_hor (
        .clk    (clock),
        .rst_n  (reset),
        .inc    (inc_hor),
        .clr    (1'b0),
        .q      (hor),
        .q_next (hor_n),
        .carry  (hor_c)
    );

    reloj_contador_alarma_contador_mod #(
        .MODULO (MIN_MAX),
        .ANCHO  (ANCHO_MS)
    ) u_min_al (
        .clk    (clock),
        .rst_n  (reset),
        .inc    (f_min_al),
        .clr    (1'b0),
        .q      (mal),
        .q_next (mal_n),
        .carry  (mal_c)
    );

    reloj_contador_alarma_contador_mod #(
        .MODULO (HORAS_MAX),
        .ANCHO  (ANCHO_H)
    ) u_hor_al (
        .clk    (clock),
        .rst_n  (reset),
        .inc    (f_hor_al),
        .clr    (1'b0),
        .q      (hal),
        .q_next (hal_n),
        .carry  (hal_c)
    );

    logic unused_carry;
    assign unused_carry = hor_c ^ mal_c ^ hal_c;

    // Trigger looks at post-update values so it fires on arrival at hh:mm:00.
    logic disparo;
    assign disparo = bus.alarma_habil && bus.tick_seg &&
                     (seg_n == '0) && (min_n == mal_n) && (hor_n == hal_n);

    estado_t               estado_q;
    estado_t               estado_d;
    logic [ANCHO_RING-1:0] ring_q;
    logic [ANCHO_RING-1:0] ring_d;
    logic                  sonando_q;
    logic                  sonando_d;

    always_comb begin
        estado_d  = estado_q;
        ring_d    = ring_q;
        case (estado_q)
            REPOSO: begin
                if (disparo) begin
                    estado_d = SONANDO;
                    ring_d   = DURACION;
                end
            end
            SONANDO: begin
                if (bus.tick_seg && ring_q != '0) begin
                    ring_d = ring_q - 1'b1;
                end
                if (bus.apagar_alarma || !bus.alarma_habil ||
                    ring_d == '0) begin
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                // Hold off until the matched minute has passed.
                if (min != mal || hor != hal) begin
                    estado_d = REPOSO;
                end
            end
            default: estado_d = REPOSO;
        endcase
        sonando_d = (estado_d == SONANDO);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= REPOSO;
            ring_q    <= '0;
            sonando_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            ring_q    <= ring_d;
            sonando_q <= sonando_d;
        end
    end

    assign bus.segundos       = seg;
    assign bus.minutos        = min;
    assign bus.horas          = hor;
    assign bus.min_al         = mal;
    assign bus.hor_al         = hal;
    assign bus.alarma_sonando = sonando_q;

endmodule

// File: doc/reloj_contador_alarma.md
Name: reloj_contador_alarma

Overview:
- Time-of-day and alarm register stage, directly downstream of the mode/function selector.
- Consumes the selector's increment requests for time and alarm, plus a 1 Hz tick, and keeps hours:minutes:seconds and alarm hours:minutes.
- Drives an alarm-ringing flag and the values for the display multiplexer.
- Single clock domain: the seconds clock arrives as a one-cycle enable, not as a gated clock.

Parameters:
- HORAS_MAX, 24, hour modulus (24 or 12; 12 counts 0..11).
- DURACION_ALARMA, 60, ring time in seconds before auto-stop (1..255).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick_seg  in  1  one-cycle pulse, once per second
- aumentar_min  in  1  level request: increment time minutes
- aumentar_hor  in  1  level request: increment time hours
- aumentar_min_al  in  1  level request: increment alarm minutes
- aumentar_hor_al  in  1  level request: increment alarm hours
- alarma_habil  in  1  alarm enabled
- apagar_alarma  in  1  level: silence a ringing alarm
- segundos  out  6  0..59
- minutos  out  6  0..59
- horas  out  5  0..HORAS_MAX-1
- min_al  out  6  alarm minutes 0..59
- hor_al  out  5  alarm hours 0..HORAS_MAX-1
- alarma_sonando  out  1  alarm ringing

Behaviour:
- Reset (reset low, asynchronous): all counters 0, alarm registers 0, edge-detect registers 0, FSM in REPOSO, alarma_sonando 0.
- Increment inputs are levels. Each one is rising-edge detected with a registered previous value; a 0->1 transition gives exactly one increment, registered 1 cycle later. A held level gives no repeat.
- Time counting on tick_seg:
  - segundos +1; 59 wraps to 0 with carry into minutos.
  - minutos 59 wraps to 0 with carry into horas.
  - horas HORAS_MAX-1 wraps to 0.
- Manual minute increment:
  - minutos +1 mod 60, with no carry into horas.
  - Clears segundos to 0.
- Manual hour increment: horas +1 mod HORAS_MAX.
- Simultaneous events in one cycle:
  - Manual minute edge beats the tick: segundos=0, minutos+1 only.
  - Manual hour edge with a tick carry into hours: hours advance by 1 only (manual edge wins, carry dropped).
  - Both manual edges in one cycle: both apply.
- Alarm registers: min_al +1 mod 60 and hor_al +1 mod HORAS_MAX on their edges; independent, no carry.
- Alarm FSM states: REPOSO, SONANDO, ESPERA.
  - REPOSO -> SONANDO when all of: alarma_habil=1; horas==hor_al and minutos==min_al; segundos==0; tick_seg seen this cycle. Entry loads the ring counter with DURACION_ALARMA.
  - SONANDO: alarma_sonando=1. Ring counter decrements on each tick_seg.
  - SONANDO -> ESPERA when apagar_alarma=1, alarma_habil=0, or the ring counter reaches 0.
  - ESPERA: alarma_sonando=0. Returns to REPOSO once minutos != min_al or horas != hor_al. This blocks re-trigger within the same minute.
- alarma_sonando is registered; it rises the cycle after the trigger tick.
- The trigger uses post-update counter values, i.e. the alarm fires as the clock arrives at hh:mm:00.
- Reset mid-ring: FSM returns to REPOSO immediately and the output is 0.
- Alarm register edits during SONANDO do not stop the ring. They only affect the ESPERA exit.
- Ring counter width: 8 bits.

Decomposition:
- Shared package holds:
  - state encodings REPOSO/SONANDO/ESPERA;
  - constants MIN_MAX=60, SEG_MAX=60;
  - field widths 6/5.
- Natural sub-module: contador_mod (parametric modulus, increment-enable, synchronous clear, carry-out). Instantiated for seconds, minutes, hours, alarm minutes and alarm hours.
- Edge detectors and FSM stay in the top module.

Test Plan:
- Reset low mid-count -> all outputs 0 asynchronously; after release, 61 tick_seg -> segundos=1, minutos=1.
- Preload 23:59:59 via increments and ticks, then one tick -> 00:00:00; with HORAS_MAX=12, 11:59:59 -> 00:00:00.
- aumentar_min held high for 10 cycles -> minutos +1 exactly once and segundos=0; minutos=59 plus an edge -> 0 with horas unchanged.
- Alarm at 07:30, alarma_habil=1, clock ticked to 07:30:00 -> alarma_sonando=1 next cycle; 60 further ticks -> 0; state ESPERA until 07:31, with no re-ring.
- Ring then apagar_alarma=1 -> alarma_sonando=0 next cycle; with alarma_habil=0 at match -> never rings.
- tick_seg coincident with an aumentar_min edge at mm:ss=05:59 -> minutos=06, segundos=00; aumentar_hor edge with carry at 03:59:59 -> horas=04.
